sandbox_rr_scheduler: RTL
=========================

Name: sandbox_rr_scheduler

Overview:
- Shares one fixed-latency 48-bit sandbox compute datapath between two host-side requesters.
- Each requester uses the sandbox level handshake: data-received is held high until a clear is returned.
- The block selects a requester round-robin, launches the datapath, captures the result, and presents it to the transmitter with a valid/ack handshake.
- It then releases the requester. It sits between the UART/host receive channels and the datapath.

Parameters:
DATA_W, 48, operand/result width.
LATENCY, 4, cycles from the dpLaunch cycle to the cycle in which dpResult is valid (legal range 1..255).
TX_TIMEOUT, 1024, cycles txValid may wait for txAck before abandoning (legal range 2..65535).

Ports:
masterClock  in  1  operating clock, all logic on its rising edge
reset  in  1  synchronous, active-low
reqValid  in  2  per-requester data-received level; bit i belongs to requester i
reqData  in  2*DATA_W  operands; requester i occupies bits [i*DATA_W +: DATA_W]
reqClear  out  2  per-requester clear; held high until the matching reqValid falls
dpData  out  DATA_W  registered operand to the datapath, stable from launch until the next launch
dpLaunch  out  1  single-cycle start pulse to the datapath
dpResult  in  DATA_W  datapath result, sampled LATENCY cycles after dpLaunch
txValid  out  1  result available for transmit
txData  out  DATA_W  captured result, stable while txValid is high
txSource  out  1  index of the requester that owns txData
txAck  in  1  transmitter accepted txData; sampled only while txValid is high
busy  out  1  high in every state except IDLE
txTimeout  out  1  sticky flag, set on any abandoned transmit; cleared only by reset

Behaviour:
Reset (reset==0 at a clock edge):
- All outputs go to 0.
- State goes to IDLE.
- lastGrant goes to 1, so requester 0 wins the first tie.
- Reset mid-operation aborts immediately: reqClear and txValid drop; no partial result is sent.

State machine:
- IDLE:
  - If any reqValid bit is set, grant it.
  - If both are set, grant the one that is not lastGrant.
  - Latch dpData from the granted requester, register grant, go to LAUNCH.
- LAUNCH:
  - dpLaunch=1 for this cycle only.
  - Load the wait counter with LATENCY; go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter reaches 1, capture dpResult into txData and set txSource=grant.
  - This capture edge is exactly LATENCY cycles after the dpLaunch cycle. Go to TX.
- TX:
  - txValid=1.
  - If txAck==1, drop txValid next cycle, assert reqClear[grant], go to RELEASE.
  - If txAck has not arrived after TX_TIMEOUT cycles of txValid, drop txValid, set txTimeout, assert reqClear[grant], go to RELEASE.
  - If txAck and timeout expiry happen on the same cycle, the ack wins and txTimeout is not set.
- RELEASE:
  - Hold reqClear[grant] high until reqValid[grant]==0 is sampled.
  - Then clear reqClear, set lastGrant=grant, go to IDLE.
- Any unused state encoding returns to IDLE with all outputs cleared.

Latency:
- reqValid is sampled high in IDLE at cycle N.
- dpLaunch is high at cycle N+1.
- txValid first goes high at cycle N+2+LATENCY.

Other rules:
- Only one job is in flight at a time.
- A requester whose reqValid drops before it is granted is simply skipped; no clear is issued.
- A reqValid that stays high after its own clear has completed is treated as a new request in the following IDLE. It is subject to round-robin.
- txAck outside TX is ignored.
- At most one reqClear bit is ever high.

Test Plan:
- Single request: reqValid=2'b01, operand 48'h0000_1234_5678, datapath model = operand+1, LATENCY=4, txAck on the 3rd txValid cycle.
  - Expected: dpLaunch at N+1; txValid at N+6 with txData=48'h0000_1234_5679 and txSource=0.
  - reqClear[0] rises after the ack and falls one cycle after reqValid[0] is dropped.
- Simultaneous requests after reset: reqValid=2'b11 with operands A and B.
  - Expected: requester 0 is served first, then requester 1, in two complete transactions.
  - txSource sequence is 0,1.
- Fairness: requester 0 re-asserts immediately after every clear while requester 1 stays asserted.
  - Expected: grants alternate 0,1,0,1 over 4 jobs.
- Timeout: TX_TIMEOUT=8, txAck held 0.
  - Expected: txValid high for exactly 8 cycles, then low.
  - txTimeout=1 and stays 1; reqClear still issued; the next job proceeds normally.
- Ack/timeout collision: txAck asserted on the 8th txValid cycle with TX_TIMEOUT=8.
  - Expected: txTimeout stays 0 and the transaction completes normally.
- Reset mid-WAIT: reset=0 for one cycle two cycles after dpLaunch.
  - Expected: busy, txValid and reqClear are 0 the next cycle; no txValid for that job.
  - A still-asserted reqValid is relaunched from IDLE.

Source files
------------

// File: rtl/sandbox_rr_scheduler.sv
// Round-robin arbiter sharing one fixed-latency datapath between two level-handshake
// requesters, with a valid/ack result port and a sticky transmit-timeout flag.
//
// state   | meaning
// IDLE    | waiting for any reqValid, picks the grant
// LAUNCH  | one-cycle dpLaunch pulse, loads the latency counter
// WAIT    | counting down datapath latency, captures dpResult at count 1
// TX      | txValid high until txAck or timeout
// RELEASE | reqClear[grant] high until reqValid[grant] falls
module sandbox_rr_scheduler #(
   parameter int DATA_W     = 48,
   parameter int LATENCY    = 4,
   parameter int TX_TIMEOUT = 1024
) (
   input  logic                  masterClock,
   input  logic                  reset,
   input  logic [1:0]            reqValid,
   input  logic [2*DATA_W-1:0]   reqData,
   output logic [1:0]            reqClear,
   output logic [DATA_W-1:0]     dpData,
   output logic                  dpLaunch,
   input  logic [DATA_W-1:0]     dpResult,
   output logic                  txValid,
   output logic [DATA_W-1:0]     txData,
   output logic                  txSource,
   input  logic                  txAck,
   output logic                  busy,
   output logic                  txTimeout
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LAUNCH  = 3'd1,
      WAIT    = 3'd2,
      TX      = 3'd3,
      RELEASE = 3'd4
   } state_t;

   localparam logic [7:0]  LAT_LOAD = 8'(LATENCY);
   localparam logic [15:0] TO_LOAD  = 16'(TX_TIMEOUT);

   state_t      state, nextState;
   logic        grant, lastGrant, nextGrant;
   logic [7:0]  waitCnt;
   logic [15:0] txTimer;

   // On a tie the requester that was not served last wins.
   always_comb begin
      nextGrant = reqValid[1];
      if (reqValid == 2'b11) nextGrant = ~lastGrant;
   end

   always_ff @(posedge masterClock) begin
      if (!reset) begin
         state     <= IDLE;
         grant     <= 1'b0;
         lastGrant <= 1'b1;
         waitCnt   <= 8'd0;
         txTimer   <= 16'd0;
         dpData    <= '0;
         txData    <= '0;
         txSource  <= 1'b0;
         txTimeout <= 1'b0;
      end else begin
         state <= nextState;
         case (state)
            IDLE: begin
               if (|reqValid) begin
                  grant  <= nextGrant;
                  dpData <= nextGrant ? reqData[DATA_W +: DATA_W] : reqData[0 +: DATA_W];
               end
            end
            LAUNCH: waitCnt <= LAT_LOAD;
            WAIT: begin
               waitCnt <= waitCnt - 8'd1;
               if (waitCnt == 8'd1) begin
                  txData   <= dpResult;
                  txSource <= grant;
                  txTimer  <= TO_LOAD;
               end
            end
            TX: begin
               txTimer <= txTimer - 16'd1;
               // An ack on the expiry cycle still counts as a normal completion.
               if (!txAck && txTimer == 16'd1) txTimeout <= 1'b1;
            end
            RELEASE: begin
               if (!reqValid[grant]) lastGrant <= grant;
            end
            default: begin
               grant    <= 1'b0;
               dpData   <= '0;
               txData   <= '0;
               txSource <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      nextState = IDLE;
      case (state)
         IDLE:    nextState = (|reqValid) ? LAUNCH : IDLE;
         LAUNCH:  nextState = WAIT;
         WAIT:    nextState = (waitCnt == 8'd1) ? TX : WAIT;
         TX:      nextState = (txAck || txTimer == 16'd1) ? RELEASE : TX;
         RELEASE: nextState = reqValid[grant] ? RELEASE : IDLE;
         default: nextState = IDLE;
      endcase
   end

   always_comb begin
      dpLaunch = 1'b0;
      txValid  = 1'b0;
      reqClear = 2'b00;
      busy     = 1'b0;
      case (state)
         IDLE:    busy = 1'b0;
         LAUNCH: begin
            busy     = 1'b1;
            dpLaunch = 1'b1;
         end
         WAIT:    busy = 1'b1;
         TX: begin
            busy    = 1'b1;
            txValid = 1'b1;
         end
         RELEASE: begin
            busy     = 1'b1;
            reqClear = grant ? 2'b10 : 2'b01;
         end
         default: busy = 1'b0;
      endcase
   end

endmodule
